// File: rtl/axi4_lite_rr_master.sv
// Two-requester AXI4-Lite master: round-robin arbitration, one outstanding read or write.
// Every output is registered, so no VALID or READY depends combinationally on the slave.
module axi4_lite_rr_master #(
    parameter int unsigned ADDRESS    = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                          ACLK,
    input  logic                          ARESET,
    input  logic [1:0]                    REQ,
    input  logic [1:0]                    REQ_WE,
    input  logic [2*ADDRESS-1:0]          REQ_ADDR,
    input  logic [2*DATA_WIDTH-1:0]       REQ_WDATA,
    input  logic [2*(DATA_WIDTH/8)-1:0]   REQ_WSTRB,
    output logic [1:0]                    GNT,
    output logic [1:0]                    DONE,
    output logic [DATA_WIDTH-1:0]         RDATA,
    output logic [1:0]                    RESP,
    output logic [ADDRESS-1:0]            M_ARADDR,
    output logic                          M_ARVALID,
    input  logic                          M_ARREADY,
    input  logic [DATA_WIDTH-1:0]         M_RDATA,
    input  logic [1:0]                    M_RRESP,
    input  logic                          M_RVALID,
    output logic                          M_RREADY,
    output logic [ADDRESS-1:0]            M_AWADDR,
    output logic                          M_AWVALID,
    input  logic                          M_AWREADY,
    output logic [DATA_WIDTH-1:0]         M_WDATA,
    output logic [DATA_WIDTH/8-1:0]       M_WSTRB,
    output logic                          M_WVALID,
    input  logic                          M_WREADY,
    input  logic [1:0]                    M_BRESP,
    input  logic                          M_BVALID,
    output logic                          M_BREADY
);

    localparam int unsigned STRB = DATA_WIDTH / 8;

    typedef enum logic [2:0] {StIdle, StRdAddr, StRdData, StWrAddrData, StWrResp} state_e;

    state_e              r_state, w_state_nxt;
    logic                r_sel, w_sel_nxt;
    logic                r_rr, w_rr_nxt;
    logic [ADDRESS-1:0]  r_addr, w_addr_nxt;
    logic [DATA_WIDTH-1:0] r_wdata, w_wdata_nxt;
    logic [STRB-1:0]     r_wstrb, w_wstrb_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic [1:0]          r_resp, w_resp_nxt;
    logic [1:0]          r_gnt, w_gnt_nxt;
    logic [1:0]          r_done, w_done_nxt;
    logic                r_arvalid, w_arvalid_nxt;
    logic                r_rready, w_rready_nxt;
    logic                r_awvalid, w_awvalid_nxt;
    logic                r_wvalid, w_wvalid_nxt;
    logic                r_bready, w_bready_nxt;
    logic                r_awch_done, w_awch_done_nxt;
    logic                r_wch_done, w_wch_done_nxt;
    logic                w_win, w_aw_fin, w_w_fin;

    always_comb begin
        w_state_nxt     = r_state;
        w_sel_nxt       = r_sel;
        w_rr_nxt        = r_rr;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_wstrb_nxt     = r_wstrb;
        w_rdata_nxt     = r_rdata;
        w_resp_nxt      = r_resp;
        w_gnt_nxt       = 2'b00;
        w_done_nxt      = 2'b00;
        w_arvalid_nxt   = r_arvalid;
        w_rready_nxt    = r_rready;
        w_awvalid_nxt   = r_awvalid;
        w_wvalid_nxt    = r_wvalid;
        w_bready_nxt    = r_bready;
        w_awch_done_nxt = r_awch_done;
        w_wch_done_nxt  = r_wch_done;
        w_win           = 1'b0;
        w_aw_fin        = r_awch_done | (r_awvalid & M_AWREADY);
        w_w_fin         = r_wch_done | (r_wvalid & M_WREADY);

        case (r_state)
            StIdle: begin
                // Skip the DONE cycle so a requester still holding REQ is not re-granted.
                if (r_done == 2'b00 && REQ != 2'b00) begin
                    w_win       = (REQ == 2'b11) ? r_rr : REQ[1];
                    w_sel_nxt   = w_win;
                    w_gnt_nxt   = {w_win, ~w_win};
                    w_addr_nxt  = w_win ? REQ_ADDR[2*ADDRESS-1 -: ADDRESS]
                                        : REQ_ADDR[ADDRESS-1:0];
                    w_wdata_nxt = w_win ? REQ_WDATA[2*DATA_WIDTH-1 -: DATA_WIDTH]
                                        : REQ_WDATA[DATA_WIDTH-1:0];
                    w_wstrb_nxt = w_win ? REQ_WSTRB[2*STRB-1 -: STRB] : REQ_WSTRB[STRB-1:0];
                    w_state_nxt = (w_win ? REQ_WE[1] : REQ_WE[0]) ? StWrAddrData : StRdAddr;
                end
            end
            StRdAddr: begin
                if (!r_arvalid) begin
                    w_arvalid_nxt = 1'b1;
                end else if (M_ARREADY) begin
                    w_arvalid_nxt = 1'b0;
                    w_rready_nxt  = 1'b1;
                    w_state_nxt   = StRdData;
                end
            end
            StRdData: begin
                if (M_RVALID) begin
                    w_rdata_nxt  = M_RDATA;
                    w_resp_nxt   = M_RRESP;
                    w_rready_nxt = 1'b0;
                    w_done_nxt   = {r_sel, ~r_sel};
                    w_rr_nxt     = ~r_sel;
                    w_state_nxt  = StIdle;
                end
            end
            StWrAddrData: begin
                if (w_aw_fin && w_w_fin) begin
                    w_awvalid_nxt   = 1'b0;
                    w_wvalid_nxt    = 1'b0;
                    w_awch_done_nxt = 1'b0;
                    w_wch_done_nxt  = 1'b0;
                    w_bready_nxt    = 1'b1;
                    w_state_nxt     = StWrResp;
                end else begin
                    // Entry cycle raises both; each then drops after its own handshake.
                    w_awvalid_nxt   = ~w_aw_fin;
                    w_wvalid_nxt    = ~w_w_fin;
                    w_awch_done_nxt = w_aw_fin;
                    w_wch_done_nxt  = w_w_fin;
                end
            end
            StWrResp: begin
                if (M_BVALID) begin
                    w_resp_nxt   = M_BRESP;
                    w_bready_nxt = 1'b0;
                    w_done_nxt   = {r_sel, ~r_sel};
                    w_rr_nxt     = ~r_sel;
                    w_state_nxt  = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state     <= StIdle;
            r_sel       <= 1'b0;
            r_rr        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_wstrb     <= '0;
            r_rdata     <= '0;
            r_resp      <= 2'b00;
            r_gnt       <= 2'b00;
            r_done      <= 2'b00;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_awch_done <= 1'b0;
            r_wch_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel       <= w_sel_nxt;
            r_rr        <= w_rr_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_wstrb     <= w_wstrb_nxt;
            r_rdata     <= w_rdata_nxt;
            r_resp      <= w_resp_nxt;
            r_gnt       <= w_gnt_nxt;
            r_done      <= w_done_nxt;
            r_arvalid   <= w_arvalid_nxt;
            r_rready    <= w_rready_nxt;
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= w_bready_nxt;
            r_awch_done <= w_awch_done_nxt;
            r_wch_done  <= w_wch_done_nxt;
        end
    end

    assign GNT       = r_gnt;
    assign DONE      = r_done;
    assign RDATA     = r_rdata;
    assign RESP      = r_resp;
    assign M_ARADDR  = r_addr;
    assign M_ARVALID = r_arvalid;
    assign M_RREADY  = r_rready;
    assign M_AWADDR  = r_addr;
    assign M_AWVALID = r_awvalid;
    assign M_WDATA   = r_wdata;
    assign M_WSTRB   = r_wstrb;
    assign M_WVALID  = r_wvalid;
    assign M_BREADY  = r_bready;

endmodule
